// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-buffer stage: access sizes, op-field layout,
// writeback selects, trap causes and FSM states.
package mem_stage_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  // mem_op = {store, unsigned, size[1:0]}
  localparam int MEM_OP_STORE    = 3;
  localparam int MEM_OP_UNSIGNED = 2;

  localparam logic [1:0] RD_SRC_ALU = 2'd0;
  localparam logic [1:0] RD_SRC_MEM = 2'd1;
  localparam logic [1:0] RD_SRC_CSR = 2'd2;
  localparam logic [1:0] RD_SRC_PC4 = 2'd3;

  localparam logic [4:0] TRAP_LD_MISAL = 5'd4;
  localparam logic [4:0] TRAP_LD_FAULT = 5'd5;
  localparam logic [4:0] TRAP_ST_MISAL = 5'd6;
  localparam logic [4:0] TRAP_ST_FAULT = 5'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mb_state_e;

  // Size code 3 is not a legal access; it is treated like a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_B: return 1'b0;
      MEM_SIZE_H: return off[0];
      MEM_SIZE_W: return off != 2'b00;
      default:    return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane steering: store strobes/data replication and
// load byte/half extraction with sign or zero extension.
module mem_stage_lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_bytes [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign ld_bytes[gi] = ld_word[8*gi +: 8];
  end

  assign ld_byte = ld_bytes[ld_off];
  assign ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      MEM_SIZE_B: begin
        st_strb  = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_SIZE_H: begin
        st_strb  = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_word;
    case (ld_size)
      MEM_SIZE_B: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      MEM_SIZE_H: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-buffer pipeline stage: issues one data-memory transaction at a time,
// reports misaligned/faulting accesses as traps and drives the writeback register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_flush,
  input  logic        ex_mb__valid,
  input  logic [31:0] ex_mb__alu_y,
  input  logic [31:0] ex_mb__rs2_rdata,
  input  logic [31:0] ex_mb__pc_4,
  input  logic [31:0] ex_mb__csr_rdata,
  input  logic [4:0]  ex_mb__rd_addr,
  input  logic        ex_mb__rd_wen,
  input  logic [1:0]  ex_mb__rd_src,
  input  logic        ex_mb__mem_en,
  input  logic [3:0]  ex_mb__mem_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err,
  output logic [31:0] mb_wb__rd_wdata,
  output logic [4:0]  mb_wb__rd_addr,
  output logic        mb_wb__rd_wen,
  output logic        mb_if__trap_taken,
  output logic [4:0]  mb_ex__trap_src,
  output logic [31:0] mb_ex__dmem_addr,
  output logic        mb_ex__instret,
  output logic        mb_stall
);

  localparam int               CNT_W    = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMEM_TIMEOUT - 1);

  mb_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      addr_reg;
  logic [3:0]       op_reg;
  logic [4:0]       rd_addr_reg;
  logic             rd_wen_reg;
  logic             killed_reg;

  logic        accept, ex_misal, go_busy, bus_done, bus_fault, timeout, discard;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata, ld_data, sel_wdata;

  assign ex_misal = is_misaligned(ex_mb__mem_op[1:0], ex_mb__alu_y[1:0]);
  // cnt_reg counts completed BUSY cycles, so this fires in the last allowed one
  assign timeout  = (cnt_reg == CNT_LAST);
  assign discard  = killed_reg | pipe_flush;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    go_busy    = 1'b0;
    bus_done   = 1'b0;
    bus_fault  = 1'b0;
    mb_stall   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        accept = ex_mb__valid & ~pipe_flush;
        if (accept & ex_mb__mem_en & ~ex_misal) begin
          go_busy    = 1'b1;
          mb_stall   = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        bus_fault = dmem_err | (timeout & ~dmem_ack);
        bus_done  = dmem_ack | bus_fault;
        if (bus_done) state_next = ST_IDLE;
        else          mb_stall   = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (ex_mb__rd_src)
      RD_SRC_CSR: sel_wdata = ex_mb__csr_rdata;
      RD_SRC_PC4: sel_wdata = ex_mb__pc_4;
      default:    sel_wdata = ex_mb__alu_y;
    endcase
  end

  mem_stage_lsu_align u_align (
    .st_off      (ex_mb__alu_y[1:0]),
    .st_size     (ex_mb__mem_op[1:0]),
    .st_data     (ex_mb__rs2_rdata),
    .st_strb     (st_strb),
    .st_wdata    (st_wdata),
    .ld_off      (addr_reg[1:0]),
    .ld_size     (op_reg[1:0]),
    .ld_unsigned (op_reg[MEM_OP_UNSIGNED]),
    .ld_word     (dmem_rdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg           <= '0;
      addr_reg          <= '0;
      op_reg            <= '0;
      rd_addr_reg       <= '0;
      rd_wen_reg        <= 1'b0;
      killed_reg        <= 1'b0;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= '0;
      dmem_wdata        <= '0;
      dmem_wstrb        <= '0;
      mb_wb__rd_wdata   <= '0;
      mb_wb__rd_addr    <= '0;
      mb_wb__rd_wen     <= 1'b0;
      mb_if__trap_taken <= 1'b0;
      mb_ex__trap_src   <= '0;
      mb_ex__dmem_addr  <= '0;
      mb_ex__instret    <= 1'b0;
    end else begin
      mb_wb__rd_wen     <= 1'b0;
      mb_if__trap_taken <= 1'b0;
      mb_ex__instret    <= 1'b0;

      if (go_busy) begin
        cnt_reg     <= '0;
        addr_reg    <= ex_mb__alu_y;
        op_reg      <= ex_mb__mem_op;
        rd_addr_reg <= ex_mb__rd_addr;
        rd_wen_reg  <= ex_mb__rd_wen;
        killed_reg  <= 1'b0;
        dmem_req    <= 1'b1;
        dmem_we     <= ex_mb__mem_op[MEM_OP_STORE];
        dmem_addr   <= {ex_mb__alu_y[31:2], 2'b00};
        dmem_wdata  <= st_wdata;
        dmem_wstrb  <= ex_mb__mem_op[MEM_OP_STORE] ? st_strb : 4'b0000;
      end else if (accept && ex_mb__mem_en) begin
        mb_if__trap_taken <= 1'b1;
        mb_ex__trap_src   <= ex_mb__mem_op[MEM_OP_STORE] ? TRAP_ST_MISAL : TRAP_LD_MISAL;
        mb_ex__dmem_addr  <= ex_mb__alu_y;
      end else if (accept) begin
        mb_wb__rd_wdata <= sel_wdata;
        mb_wb__rd_addr  <= ex_mb__rd_addr;
        mb_wb__rd_wen   <= ex_mb__rd_wen & (ex_mb__rd_addr != 5'd0);
        mb_ex__instret  <= 1'b1;
      end

      if (state_reg == ST_BUSY) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (pipe_flush) killed_reg <= 1'b1;
        if (bus_done) begin
          dmem_req   <= 1'b0;
          dmem_we    <= 1'b0;
          dmem_wstrb <= 4'b0000;
          // A flushed access still finishes on the bus but leaves no architectural trace
          if (!discard) begin
            if (bus_fault) begin
              mb_if__trap_taken <= 1'b1;
              mb_ex__trap_src   <= op_reg[MEM_OP_STORE] ? TRAP_ST_FAULT : TRAP_LD_FAULT;
              mb_ex__dmem_addr  <= addr_reg;
            end else begin
              mb_ex__instret <= 1'b1;
              if (!op_reg[MEM_OP_STORE]) begin
                mb_wb__rd_wdata <= ld_data;
                mb_wb__rd_addr  <= rd_addr_reg;
                mb_wb__rd_wen   <= rd_wen_reg & (rd_addr_reg != 5'd0);
              end
            end
          end
        end
      end
    end
  end

endmodule
